// File: rtl/mod_updown_counter_pkg.sv
// counter_pkg: shared direction type and modulus limit/clamp helpers for the up/down counter.
package counter_pkg;
   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;
   function automatic longint unsigned limit(input longint unsigned modulus);
      return modulus - 64'd1;
   endfunction
   function automatic longint unsigned clamp(input longint unsigned v, input longint unsigned modulus);
      return (v > limit(modulus)) ? limit(modulus) : v;
   endfunction
endpackage

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and status bundle of the up/down counter.
interface mod_updown_counter_if #(parameter int WIDTH = 4);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             carry;
   modport master (output en, up, load, load_val, input q, tc, carry);
   modport slave  (input en, up, load, load_val, output q, tc, carry);
endinterface

// File: rtl/mod_updown_counter_step.sv
// mod_step: combinational next-count and limit detection with wrap/saturate policy.
module mod_step
   import counter_pkg::*;
#(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter bit              SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   output logic [WIDTH-1:0] next,
   output logic             at_limit
);
   localparam logic [WIDTH:0] LIM = (WIDTH+1)'(limit(MODULUS));
   count_dir_e dir;
   logic [WIDTH:0] qx, nx;
   // one extra bit keeps q-1 at 0 and q+1 at all-ones from aliasing
   always_comb begin
      dir      = count_dir_e'(up);
      qx       = {1'b0, q};
      at_limit = (dir == DIR_UP) ? (qx == LIM) : (qx == '0);
      nx       = at_limit ? (SATURATE ? qx : ((dir == DIR_UP) ? '0 : LIM))
                          : ((dir == DIR_UP) ? qx + (WIDTH+1)'(1) : qx - (WIDTH+1)'(1));
      next     = WIDTH'(nx);
   end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down counter with load, modulus, saturate and carry flag.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter bit              SATURATE = 1'b0
) (
   input logic                 clk,
   input logic                 clr,
   mod_updown_counter_if.slave bus
);
   if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_param_err
      $error("mod_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end
   logic [WIDTH-1:0] q_r, next, load_q;
   logic             at_limit, carry_r;
   mod_step #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(SATURATE)) u_step (
      .q        (q_r),
      .up       (bus.up),
      .next     (next),
      .at_limit (at_limit)
   );
   assign load_q = WIDTH'(clamp(64'(bus.load_val), MODULUS));
   always_ff @(posedge clk) begin
      if (clr) begin
         q_r     <= '0;
         carry_r <= 1'b0;
      end else if (bus.load) begin
         q_r     <= load_q;
         carry_r <= 1'b0;
      end else if (bus.en) begin
         q_r     <= next;
         carry_r <= at_limit;
      end else begin
         carry_r <= 1'b0;
      end
   end
   assign bus.q     = q_r;
   assign bus.tc    = at_limit;
   assign bus.carry = carry_r;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench over three counter configurations sharing one stimulus.
module tb_mod_updown_counter;
   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;

   mod_updown_counter_if #(.WIDTH(4)) i0 ();
   mod_updown_counter_if #(.WIDTH(4)) i1 ();
   mod_updown_counter_if #(.WIDTH(4)) i2 ();
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) d0 (.clk(clk), .clr(clr), .bus(i0));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) d1 (.clk(clk), .clr(clr), .bus(i1));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) d2 (.clk(clk), .clr(clr), .bus(i2));

   logic [3:0] dq[3];
   logic       dtc[3], dc[3];
   assign dq[0] = i0.q;  assign dtc[0] = i0.tc;  assign dc[0] = i0.carry;
   assign dq[1] = i1.q;  assign dtc[1] = i1.tc;  assign dc[1] = i1.carry;
   assign dq[2] = i2.q;  assign dtc[2] = i2.tc;  assign dc[2] = i2.carry;

   typedef struct {int q; bit tc; bit c;} exp_t;
   exp_t sb[$];
   int   m_q[3]  = '{0, 0, 0};
   int   mods[3] = '{10, 10, 16};
   bit   sats[3] = '{1'b0, 1'b1, 1'b0};

   task automatic tick(input bit c, input bit e, input bit u, input bit l, input int lv);
      exp_t x;
      bit   cy;
      clr = c;
      i0.en = e; i0.up = u; i0.load = l; i0.load_val = 4'(lv);
      i1.en = e; i1.up = u; i1.load = l; i1.load_val = 4'(lv);
      i2.en = e; i2.up = u; i2.load = l; i2.load_val = 4'(lv);
      for (int k = 0; k < 3; k++) begin
         cy = 1'b0;
         if (c) m_q[k] = 0;
         else if (l) m_q[k] = (lv > mods[k] - 1) ? mods[k] - 1 : lv;
         else if (e && u) begin
            if (m_q[k] == mods[k] - 1) begin cy = 1'b1; if (!sats[k]) m_q[k] = 0; end
            else m_q[k]++;
         end else if (e) begin
            if (m_q[k] == 0) begin cy = 1'b1; if (!sats[k]) m_q[k] = mods[k] - 1; end
            else m_q[k]--;
         end
         x.q  = m_q[k];
         x.tc = u ? (m_q[k] == mods[k] - 1) : (m_q[k] == 0);
         x.c  = cy;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         x = sb.pop_front();
         checks++;
         if (dq[k] !== 4'(x.q) || dtc[k] !== x.tc || dc[k] !== x.c) begin
            failures++;
            $display("FAIL scoreboard dut%0d t=%0t: q=%0d tc=%b carry=%b, expected q=%0d tc=%b carry=%b",
                     k, $time, dq[k], dtc[k], dc[k], x.q, x.tc, x.c);
         end
      end
   endtask

   task automatic test_reset();
      tick(1, 0, 1, 0, 0);
      tick(1, 1, 1, 1, 7);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dq[k] !== 4'd0 || dc[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset dut%0d: q=%0d carry=%b, expected q=0 carry=0", k, dq[k], dc[k]);
         end
      end
   endtask

   task automatic test_count_up();
      logic [3:0] seq[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      for (int i = 0; i < 12; i++) begin
         tick(0, 1, 1, 0, 0);
         checks++;
         if (dq[0] !== seq[i] || dc[0] !== (i == 9) || dtc[0] !== (seq[i] == 4'd9)) begin
            failures++;
            $display("FAIL count_up step%0d: q=%0d carry=%b tc=%b, expected q=%0d carry=%b tc=%b",
                     i, dq[0], dc[0], dtc[0], seq[i], i == 9, seq[i] == 4'd9);
         end
      end
   endtask

   task automatic test_count_down_wrap();
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0);
      checks++;
      if (dq[0] !== 4'd9 || dc[0] !== 1'b1) begin
         failures++;
         $display("FAIL down_wrap: q=%0d carry=%b, expected q=9 carry=1", dq[0], dc[0]);
      end
      tick(0, 1, 0, 0, 0);
      checks++;
      if (dq[0] !== 4'd8 || dc[0] !== 1'b0) begin
         failures++;
         $display("FAIL down_next: q=%0d carry=%b, expected q=8 carry=0", dq[0], dc[0]);
      end
   endtask

   task automatic test_saturate();
      tick(0, 0, 1, 1, 8);
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 1, 0, 0);
         checks++;
         if (dq[1] !== 4'd9 || dc[1] !== (i > 0)) begin
            failures++;
            $display("FAIL saturate step%0d: q=%0d carry=%b, expected q=9 carry=%b", i, dq[1], dc[1], i > 0);
         end
      end
   endtask

   task automatic test_load_clamp();
      tick(0, 0, 1, 1, 13);
      checks++;
      if (dq[0] !== 4'd9 || dq[2] !== 4'd13) begin
         failures++;
         $display("FAIL load_clamp: q_m10=%0d q_m16=%0d, expected 9 and 13", dq[0], dq[2]);
      end
      tick(0, 1, 1, 1, 3);
      checks++;
      if (dq[0] !== 4'd3 || dc[0] !== 1'b0) begin
         failures++;
         $display("FAIL load_over_en: q=%0d carry=%b, expected q=3 carry=0", dq[0], dc[0]);
      end
   endtask

   task automatic test_clr_priority();
      tick(0, 0, 1, 1, 5);
      tick(1, 1, 1, 1, 3);
      checks++;
      if (dq[0] !== 4'd0 || dc[0] !== 1'b0) begin
         failures++;
         $display("FAIL clr_priority: q=%0d carry=%b, expected q=0 carry=0", dq[0], dc[0]);
      end
      tick(0, 1, 1, 0, 0);
      checks++;
      if (dq[0] !== 4'd1) begin
         failures++;
         $display("FAIL clr_resume: q=%0d, expected 1", dq[0]);
      end
   endtask

   task automatic test_binary_wrap();
      tick(0, 0, 1, 1, 15);
      tick(0, 1, 1, 0, 0);
      checks++;
      if (dq[2] !== 4'd0 || dc[2] !== 1'b1) begin
         failures++;
         $display("FAIL binwrap_up: q=%0d carry=%b, expected q=0 carry=1", dq[2], dc[2]);
      end
      tick(0, 1, 0, 0, 0);
      checks++;
      if (dq[2] !== 4'd15 || dc[2] !== 1'b1) begin
         failures++;
         $display("FAIL binwrap_down: q=%0d carry=%b, expected q=15 carry=1", dq[2], dc[2]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++)
         tick($urandom_range(99) < 2, $urandom_range(99) < 70, 1'($urandom),
              $urandom_range(99) < 10, int'($urandom_range(15)));
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down_wrap();
      test_saturate();
      test_load_clamp();
      test_clr_priority();
      test_binary_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
